// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if
//   Bundles the FIFO read port and the packed-word valid/ready output of
//   fifo_rd_packer.
//   FIFO side : rempty, rdata (first-word-fall-through head), rinc (pop strobe)
//   Control   : flush (one-cycle request to emit a partial word)
//   Output    : out_valid, out_ready, out_data, out_count, out_last
//   master = the packer, slave = the environment (FIFO + downstream sink).
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int CNT_W      = $clog2(LANES) + 1
);
    logic                        rempty;
    logic [DATA_WIDTH-1:0]       rdata;
    logic                        rinc;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH*LANES-1:0] out_data;
    logic [CNT_W-1:0]            out_count;
    logic                        out_last;

    modport master (
        input  rempty, rdata, flush, out_ready,
        output rinc, out_valid, out_data, out_count, out_last
    );

    modport slave (
        output rempty, rdata, flush, out_ready,
        input  rinc, out_valid, out_data, out_count, out_last
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-domain consumer of an async FIFO. Pops DATA_WIDTH-bit entries while
//   the FIFO is non-empty and packs LANES consecutive entries into one word
//   (entry 0 in the LSBs), presented on a valid/ready output. A flush pulse
//   forces out any partial word with out_last=1.
//   Ports:
//     rclk : read-domain clock, all state on rising edge
//     rrst : asynchronous active-high reset
//     bus  : fifo_rd_packer_if.master (FIFO read port, flush, output word)
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int CNT_W      = $clog2(LANES) + 1
) (
    input logic              rclk,
    input logic              rrst,
    fifo_rd_packer_if.master bus
);
    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [0:0] {
        FILL       = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_t;

    state_t                            state, state_nx;
    logic [LANES-2:0][DATA_WIDTH-1:0]  acc, acc_nx;
    logic [LANES-1:0][DATA_WIDTH-1:0]  word;
    logic [LW-1:0]                     lane_cnt, cnt_nx;
    logic                              slot_free;
    logic                              pop;
    logic [CNT_W-1:0]                  n;
    logic                              load;
    logic                              load_last;
    logic [CNT_W-1:0]                  load_count;

    assign slot_free = !bus.out_valid || bus.out_ready;
    assign pop       = !rrst && !bus.rempty && (state == FILL) &&
                       ((lane_cnt < LAST_LANE) || slot_free);
    assign bus.rinc  = pop;
    assign n         = CNT_W'(lane_cnt) + CNT_W'(pop);

    // Accumulator with this edge's popped entry merged in. Lanes at or above
    // the fill point are already zero because the accumulator is cleared on
    // every emit, so this is also the zero-padded partial word for a flush.
    always_comb begin
        word            = '0;
        word[LANES-2:0] = acc;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (pop && lane_cnt == LW'(i)) begin
                word[i] = bus.rdata;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        acc_nx     = acc;
        cnt_nx     = lane_cnt;
        load       = 1'b0;
        load_last  = 1'b0;
        load_count = '0;
        unique case (state)
            FILL: begin
                if (pop && lane_cnt == LAST_LANE) begin
                    // Completing pop implies slot_free; a coincident flush is absorbed.
                    load       = 1'b1;
                    load_count = CNT_W'(LANES);
                    load_last  = bus.flush;
                    acc_nx     = '0;
                    cnt_nx     = '0;
                end else if (bus.flush && n != '0) begin
                    if (slot_free) begin
                        load       = 1'b1;
                        load_count = n;
                        load_last  = 1'b1;
                        acc_nx     = '0;
                        cnt_nx     = '0;
                    end else begin
                        state_nx = FLUSH_WAIT;
                        acc_nx   = word[LANES-2:0];
                        cnt_nx   = LW'(n);
                    end
                end else if (pop) begin
                    acc_nx = word[LANES-2:0];
                    cnt_nx = lane_cnt + 1'b1;
                end
            end
            FLUSH_WAIT: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_count = CNT_W'(lane_cnt);
                    load_last  = 1'b1;
                    acc_nx     = '0;
                    cnt_nx     = '0;
                    state_nx   = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            acc           <= '0;
            lane_cnt      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            acc      <= acc_nx;
            lane_cnt <= cnt_nx;
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= word;
                bus.out_count <= load_count;
                bus.out_last  <= load_last;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer
//   Directed bench for fifo_rd_packer (DATA_WIDTH=8, LANES=4). A queue models
//   the first-word-fall-through FIFO; every expected value is hand-computed.
module tb_fifo_rd_packer;
    logic rclk;
    logic rrst;
    int   errors;
    int   checks;
    int   pops;
    logic [7:0] fifo_q[$];

    fifo_rd_packer_if #(.DATA_WIDTH(8), .LANES(4)) bus ();

    fifo_rd_packer #(.DATA_WIDTH(8), .LANES(4)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    initial rclk = 1'b0;
    always #10 rclk = ~rclk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        bus.rempty = (fifo_q.size() == 0);
        bus.rdata  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    // One clock: rinc sampled on the falling edge, FIFO head advanced just after the rise.
    task automatic cycle();
        logic took;
        @(negedge rclk);
        took = bus.rinc;
        @(posedge rclk);
        #1;
        if (took) begin
            pops++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        refresh();
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic [2:0] c, input logic l);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"},  bus.out_data, d);
        chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
        chk({tag, "_last"},  32'(bus.out_last), 32'(l));
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        pops          = 0;
        rrst          = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // 1: reset with a non-empty FIFO
        for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
        #1;
        chk("rst_rinc0", 32'(bus.rinc), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  bus.out_data, 32'h0);
        chk("rst_count", 32'(bus.out_count), 32'd0);
        chk("rst_last",  32'(bus.out_last), 32'd0);
        repeat (3) begin
            cycle();
            #1;
            chk("rst_rinc", 32'(bus.rinc), 32'd0);
        end
        chk("rst_pops", pops, 0);
        rrst          = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("t2_rinc", 32'(bus.rinc), 32'd1);

        // 2: two back-to-back full words
        pops = 0;
        repeat (3) cycle();
        chk("t2_novalid", 32'(bus.out_valid), 32'd0);
        cycle();
        chk_word("t2_w0", 32'h44332211, 3'd4, 1'b0);
        repeat (4) cycle();
        chk_word("t2_w1", 32'h88776655, 3'd4, 1'b0);
        chk("t2_pops", pops, 8);
        cycle();
        #1;
        chk("t2_drain", 32'(bus.out_valid), 32'd0);
        chk("t2_rinc_empty", 32'(bus.rinc), 32'd0);

        // 3: backpressure
        bus.out_ready = 1'b0;
        pops = 0;
        for (int i = 1; i <= 7; i++) push(8'(i));
        repeat (4) cycle();
        chk_word("t3_w0", 32'h04030201, 3'd4, 1'b0);
        repeat (3) cycle();
        chk_word("t3_hold", 32'h04030201, 3'd4, 1'b0);
        chk("t3_pops7", pops, 7);
        push(8'h08);
        #1;
        chk("t3_rinc_blk", 32'(bus.rinc), 32'd0);
        cycle();
        chk("t3_pops_stall", pops, 7);
        chk_word("t3_hold2", 32'h04030201, 3'd4, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk("t3_rinc_go", 32'(bus.rinc), 32'd1);
        cycle();
        chk_word("t3_w1", 32'h08070605, 3'd4, 1'b0);
        chk("t3_pops8", pops, 8);
        cycle();
        chk("t3_drain", 32'(bus.out_valid), 32'd0);

        // 4: partial flush, then flush of an empty packer
        pops = 0;
        push(8'hA1);
        push(8'hB2);
        repeat (2) cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        chk_word("t4_part", 32'h0000B2A1, 3'd2, 1'b1);
        chk("t4_pops", pops, 2);
        cycle();
        chk("t4_drain", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        chk("t4_empty_flush", 32'(bus.out_valid), 32'd0);
        cycle();
        chk("t4_empty_flush2", 32'(bus.out_valid), 32'd0);

        // 5: flush while the output slot is stalled
        bus.out_ready = 1'b0;
        pops = 0;
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); push(8'hC3);
        repeat (5) cycle();
        chk_word("t5_full", 32'hD4D3D2D1, 3'd4, 1'b0);
        chk("t5_pops5", pops, 5);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        push(8'hC4); push(8'hC5); push(8'hC6); push(8'hC7);
        #1;
        chk("t5_rinc_wait", 32'(bus.rinc), 32'd0);
        chk_word("t5_hold", 32'hD4D3D2D1, 3'd4, 1'b0);
        cycle();
        chk("t5_pops_wait", pops, 5);
        bus.out_ready = 1'b1;
        #1;
        chk("t5_rinc_wait2", 32'(bus.rinc), 32'd0);
        cycle();
        chk_word("t5_part", 32'h000000C3, 3'd1, 1'b1);
        chk("t5_pops_emit", pops, 5);
        repeat (4) cycle();
        chk_word("t5_resume", 32'hC7C6C5C4, 3'd4, 1'b0);
        chk("t5_pops9", pops, 9);
        cycle();
        chk("t5_drain", 32'(bus.out_valid), 32'd0);

        // 6a: flush coincident with the completing pop
        pops = 0;
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        repeat (3) cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        chk_word("t6_absorb", 32'hE4E3E2E1, 3'd4, 1'b1);
        cycle();
        chk("t6_drain", 32'(bus.out_valid), 32'd0);
        chk("t6_pops4", pops, 4);

        // 6b: reset mid-word with a word pending
        bus.out_ready = 1'b0;
        pops = 0;
        push(8'hF0); push(8'hF1); push(8'hF2); push(8'hF3);
        repeat (4) cycle();
        chk_word("t6_pend", 32'hF3F2F1F0, 3'd4, 1'b0);
        push(8'hF4); push(8'hF5);
        repeat (2) cycle();
        chk("t6_pops6", pops, 6);
        push(8'hF6);
        #4;
        rrst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_async_data",  bus.out_data, 32'h0);
        chk("t6_async_count", 32'(bus.out_count), 32'd0);
        chk("t6_rst_rinc",    32'(bus.rinc), 32'd0);
        cycle();
        chk("t6_rst_pops", pops, 6);
        rrst          = 1'b0;
        bus.out_ready = 1'b1;
        push(8'hF7); push(8'hF8); push(8'hF9);
        #1;
        chk("t6_post_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_post_rinc",  32'(bus.rinc), 32'd1);
        repeat (4) cycle();
        chk_word("t6_fresh", 32'hF9F8F7F6, 3'd4, 1'b0);
        chk("t6_pops10", pops, 10);
        cycle();
        chk("t6_drain2", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
